// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one SRAM-like port between inst and data requesters.
// Optional ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of data-over-inst priority.
module mem_port_arbiter #(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOCK_INST = 2'd1,
      LOCK_DATA = 2'd2
   } state_t;

   state_t                     state;
   logic [CNT_W-1:0]           cnt;
   logic [PTR_W-1:0]           wr_ptr;
   logic [PTR_W-1:0]           rd_ptr;
   logic [MAX_OUTSTANDING-1:0] owner_q;

   logic sel_data;
   logic req_raw;
   logic full;
   logic q_empty;
   logic push;
   logic pop;
   logic head_data;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_gnt_data;
`endif

   // Full uses registered cnt only so bus_data_ok never reaches bus_req.
   assign full    = (cnt == CNT_MAX);
   assign q_empty = (cnt == '0);

   always_comb begin
      sel_data = 1'b0;
      req_raw  = 1'b0;
      case (state)
         LOCK_INST: begin
            sel_data = 1'b0;
            req_raw  = inst_req;
         end
         LOCK_DATA: begin
            sel_data = 1'b1;
            req_raw  = data_req;
         end
         default: begin
`ifdef ARB_ROUND_ROBIN_EN
            sel_data = data_req && (!inst_req || !last_gnt_data);
`else
            sel_data = data_req;
`endif
            req_raw  = !full && (inst_req || data_req);
         end
      endcase
   end

   assign bus_req   = resetn && req_raw;
   assign bus_wr    = bus_req && (sel_data ? data_wr : inst_wr);
   assign bus_size  = {2{bus_req}}  & (sel_data ? data_size  : inst_size);
   assign bus_addr  = {32{bus_req}} & (sel_data ? data_addr  : inst_addr);
   assign bus_wstrb = {4{bus_req}}  & (sel_data ? data_wstrb : inst_wstrb);
   assign bus_wdata = {32{bus_req}} & (sel_data ? data_wdata : inst_wdata);

   assign push = bus_req && bus_addr_ok;
   assign pop  = resetn && bus_data_ok && !q_empty;

   assign inst_addr_ok = push && !sel_data;
   assign data_addr_ok = push &&  sel_data;

   assign head_data    = owner_q[rd_ptr];
   assign inst_data_ok = pop && !head_data;
   assign data_data_ok = pop &&  head_data;
   assign inst_rdata   = bus_rdata;
   assign data_rdata   = bus_rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus_req && !bus_addr_ok)
                  state <= sel_data ? LOCK_DATA : LOCK_INST;
            end
            LOCK_INST, LOCK_DATA: begin
               if (bus_addr_ok)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Owner queue: one bit per accepted transaction, 1 = data requester.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner_q <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt     <= '0;
      end else begin
         if (push) begin
            owner_q[wr_ptr] <= sel_data;
            wr_ptr          <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         last_gnt_data <= 1'b1;
      else if (push)
         last_gnt_data <= sel_data;
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and random checks of mem_port_arbiter against a queue model.
module tb_mem_port_arbiter;
   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic [3:0]  inst_wstrb, data_wstrb;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        bus_req, bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_wstrb;
   logic        bus_addr_ok, bus_data_ok;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
      .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
   );

   int checks = 0;
   int errors = 0;

   // Model: queue of owners in issue order (0 = inst, 1 = data), held owner, last winner.
   int   mq[$];
   int   lock_own = -1;
   int   last_gnt = 1;
   logic e_iaok, e_daok;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      int          own;
      logic        ereq, ewr, eiok, edok;
      logic [1:0]  esize;
      logic [31:0] eaddr, ewdata;
      logic [3:0]  ewstrb;
      own  = 0;
      ereq = 1'b0;
      if (!resetn) begin
         ereq = 1'b0;
      end else if (lock_own >= 0) begin
         own  = lock_own;
         ereq = (own == 1) ? data_req : inst_req;
      end else if (mq.size() < MAXO && (inst_req || data_req)) begin
         ereq = 1'b1;
         if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            own = (last_gnt == 1) ? 0 : 1;
`else
            own = 1;
`endif
         end else begin
            own = data_req ? 1 : 0;
         end
      end
      ewr    = ereq && ((own == 1) ? data_wr : inst_wr);
      esize  = !ereq ? 2'd0  : ((own == 1) ? data_size  : inst_size);
      eaddr  = !ereq ? 32'd0 : ((own == 1) ? data_addr  : inst_addr);
      ewstrb = !ereq ? 4'd0  : ((own == 1) ? data_wstrb : inst_wstrb);
      ewdata = !ereq ? 32'd0 : ((own == 1) ? data_wdata : inst_wdata);
      e_iaok = ereq && bus_addr_ok && own == 0;
      e_daok = ereq && bus_addr_ok && own == 1;
      eiok   = resetn && bus_data_ok && mq.size() > 0 && mq[0] == 0;
      edok   = resetn && bus_data_ok && mq.size() > 0 && mq[0] == 1;

      chk("bus_req",      32'(bus_req),      32'(ereq));
      chk("bus_wr",       32'(bus_wr),       32'(ewr));
      chk("bus_size",     32'(bus_size),     32'(esize));
      chk("bus_addr",     bus_addr,          eaddr);
      chk("bus_wstrb",    32'(bus_wstrb),    32'(ewstrb));
      chk("bus_wdata",    bus_wdata,         ewdata);
      chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_iaok));
      chk("data_addr_ok", 32'(data_addr_ok), 32'(e_daok));
      chk("inst_data_ok", 32'(inst_data_ok), 32'(eiok));
      chk("data_data_ok", 32'(data_data_ok), 32'(edok));
      if (eiok) chk("inst_rdata", inst_rdata, bus_rdata);
      if (edok) chk("data_rdata", data_rdata, bus_rdata);

      if (!resetn) begin
         mq.delete();
         lock_own = -1;
         last_gnt = 1;
      end else begin
         if (eiok || edok) void'(mq.pop_front());
         if (ereq && bus_addr_ok) begin
            mq.push_back(own);
            lock_own = -1;
            last_gnt = own;
         end else if (ereq) begin
            lock_own = own;
         end else if (lock_own >= 0 && bus_addr_ok) begin
            lock_own = -1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_inst(input logic rq, input logic [31:0] a);
      inst_req = rq; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = a;
      inst_wstrb = 4'h0; inst_wdata = 32'h0;
   endtask

   task automatic set_data(input logic rq, input logic [31:0] a);
      data_req = rq; data_wr = 1'b0; data_size = 2'd2; data_addr = a;
      data_wstrb = 4'h0; data_wdata = 32'h0;
   endtask

   task automatic drain();
      inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0;
      for (int i = 0; i < 8 && mq.size() > 0; i++) begin
         bus_data_ok = 1'b1; bus_rdata = $urandom;
         #2; step();
      end
      bus_data_ok = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      set_inst(1'b1, 32'h1234_5678);
      set_data(1'b1, 32'h8765_4321);
      bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h0;
      @(posedge clk); #1;

      // Reset state
      #2;
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      chk("rst_data_data_ok", 32'(data_data_ok), 32'd0);
      step();
      resetn = 1'b1;
      set_inst(1'b0, 32'h0); set_data(1'b0, 32'h0);
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      #2; step();

      // Inst then data, responses routed in order
      set_inst(1'b1, 32'hBFC0_0000); bus_addr_ok = 1'b1;
      #2;
      chk("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      chk("t1_bus_addr", bus_addr, 32'hBFC0_0000);
      step();
      set_inst(1'b0, 32'h0); set_data(1'b1, 32'h8000_1000);
      bus_data_ok = 1'b1; bus_rdata = 32'h1111_1111;
      #2;
      chk("t1_data_addr_ok", 32'(data_addr_ok), 32'd1);
      chk("t1_inst_data_ok", 32'(inst_data_ok), 32'd1);
      chk("t1_inst_rdata", inst_rdata, 32'h1111_1111);
      chk("t1_no_cross_data", 32'(data_data_ok), 32'd0);
      step();
      set_data(1'b0, 32'h0); bus_addr_ok = 1'b0; bus_rdata = 32'h2222_2222;
      #2;
      chk("t1_data_data_ok", 32'(data_data_ok), 32'd1);
      chk("t1_data_rdata", data_rdata, 32'h2222_2222);
      chk("t1_no_cross_inst", 32'(inst_data_ok), 32'd0);
      step();
      drain();

      // Simultaneous requests
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = 0; k < 4; k++) begin
         set_inst(1'b1, 32'h100 + 32'(k)); set_data(1'b1, 32'h200 + 32'(k));
         bus_addr_ok = 1'b1; bus_data_ok = (k > 0); bus_rdata = $urandom;
         #2;
         chk("rr_inst_grant", 32'(inst_addr_ok), 32'(k % 2 == 0));
         chk("rr_data_grant", 32'(data_addr_ok), 32'(k % 2 == 1));
         step();
      end
`else
      set_inst(1'b1, 32'h100); set_data(1'b1, 32'h200); bus_addr_ok = 1'b1;
      #2;
      chk("fp_data_first", 32'(data_addr_ok), 32'd1);
      chk("fp_inst_waits", 32'(inst_addr_ok), 32'd0);
      step();
      set_data(1'b0, 32'h0);
      #2;
      chk("fp_inst_second", 32'(inst_addr_ok), 32'd1);
      step();
`endif
      drain();

      // Lock hold
      set_data(1'b1, 32'hA000_0040); bus_addr_ok = 1'b0;
      #2; step();
      set_inst(1'b1, 32'hBFC0_0100);
      for (int k = 0; k < 2; k++) begin
         #2;
         chk("lock_bus_addr", bus_addr, 32'hA000_0040);
         chk("lock_no_inst_ok", 32'(inst_addr_ok), 32'd0);
         step();
      end
      bus_addr_ok = 1'b1;
      #2;
      chk("lock_data_accept", 32'(data_addr_ok), 32'd1);
      step();
      set_data(1'b0, 32'h0);
      #2;
      chk("lock_inst_next", 32'(inst_addr_ok), 32'd1);
      chk("lock_inst_addr", bus_addr, 32'hBFC0_0100);
      step();
      drain();

      // Full
      set_inst(1'b1, 32'h1000); bus_addr_ok = 1'b1;
      #2; step();
      set_inst(1'b1, 32'h1004);
      #2; step();
      set_inst(1'b1, 32'h1008);
      #2;
      chk("full_no_req", 32'(bus_req), 32'd0);
      chk("full_no_aok", 32'(inst_addr_ok), 32'd0);
      step();
      bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_0001;
      #2;
      chk("full_pop_no_req", 32'(bus_req), 32'd0);
      chk("full_pop_dok", 32'(inst_data_ok), 32'd1);
      step();
      bus_data_ok = 1'b0;
      #2;
      chk("full_resume", 32'(bus_req), 32'd1);
      chk("full_resume_aok", 32'(inst_addr_ok), 32'd1);
      step();
      drain();

      // Sustained push and pop
      set_inst(1'b1, 32'h2000); bus_addr_ok = 1'b1;
      #2; step();
      for (int k = 1; k <= 10; k++) begin
         set_inst(k % 2 == 0, 32'h2000 + 32'(4 * k));
         set_data(k % 2 == 1, 32'h3000 + 32'(4 * k));
         bus_data_ok = 1'b1; bus_rdata = $urandom;
         #2;
         if ((k - 1) % 2 == 0) chk("pp_inst_dok", 32'(inst_data_ok), 32'd1);
         else                  chk("pp_data_dok", 32'(data_data_ok), 32'd1);
         step();
      end
      drain();

      // Reset mid-operation
      set_data(1'b1, 32'h4000); bus_addr_ok = 1'b1;
      #2; step();
      set_data(1'b0, 32'h0); set_inst(1'b1, 32'h5000); bus_addr_ok = 1'b0;
      #2; step();
      #2;
      resetn = 1'b0;
      #1;
      chk("mid_rst_bus_req", 32'(bus_req), 32'd0);
      chk("mid_rst_bus_addr", bus_addr, 32'd0);
      chk("mid_rst_inst_aok", 32'(inst_addr_ok), 32'd0);
      step();
      resetn = 1'b1; set_inst(1'b0, 32'h0); bus_data_ok = 1'b1;
      #2;
      chk("stray_inst_dok", 32'(inst_data_ok), 32'd0);
      chk("stray_data_dok", 32'(data_data_ok), 32'd0);
      step();
      bus_data_ok = 1'b0;

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         if (!inst_req && $urandom_range(2) == 0) begin
            inst_req = 1'b1; inst_wr = 1'($urandom); inst_size = 2'($urandom);
            inst_addr = $urandom; inst_wstrb = 4'($urandom); inst_wdata = $urandom;
         end
         if (!data_req && $urandom_range(2) == 0) begin
            data_req = 1'b1; data_wr = 1'($urandom); data_size = 2'($urandom);
            data_addr = $urandom; data_wstrb = 4'($urandom); data_wdata = $urandom;
         end
         bus_addr_ok = ($urandom_range(4) < 3);
         bus_data_ok = (mq.size() > 0) ? 1'($urandom) : ($urandom_range(15) == 0);
         bus_rdata   = $urandom;
         #2; step();
         if (e_iaok) inst_req = 1'b0;
         if (e_daok) data_req = 1'b0;
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
